// File: rtl/ifetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM state
// encoding and word-alignment constants.
package ifetch_ctrl_pkg;

  // ISSUE : idle, next edge launches a read of the current PC
  // WAIT  : read outstanding, data will be delivered
  // HOLD  : delivered instruction parked while ID is stalled
  // DRAIN : read outstanding but squashed by a flush, data will be dropped
  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_e;

  // Instruction words are 4-byte aligned.
  localparam int unsigned WORD_LSBS = 2;

endpackage

// File: rtl/ifetch_ctrl_fetch_timer.sv
// Watchdog for an outstanding instruction read. Counts cycles while enabled,
// clears when disabled and saturates at TIMEOUT-1. err_o goes high in the same
// cycle the count reaches TIMEOUT-1 and stays high until reset.
module fetch_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic start_i,
  input  logic en_i,
  output logic err_o
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  logic [TW-1:0] count_q;
  logic          err_q;

  // Saturating cycle counter with a sticky overflow flag.
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (en_i) begin
      if (count_q != TW'(TIMEOUT - 1)) begin
        count_q <= count_q + TW'(1);
      end
      if (count_q == TW'(TIMEOUT - 2)) begin
        err_q <= 1'b1;
      end
    end else begin
      count_q <= '0;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch-side controller between the PC register and instruction memory.
// Runs one outstanding req/ack read at a time and hands the word to IF/ID.
// stall_o holds the PC until the fetched instruction is consumed or a flush
// redirects it.
//
// Memory handshake: mem_req_o rises with a stable mem_addr_o and stays high
// until the cycle in which mem_ack_i=1 (that cycle carries mem_data_i); it
// drops on the following edge. mem_ack_i is ignored while mem_req_o=0.
module ifetch_ctrl
  import ifetch_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] inst_o,
  output logic              inst_valid_o,
  output logic [31:0]       fetch_cnt_o,
  output logic              err_o,
  output logic [1:0]        dbg_state_o
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << WORD_LSBS) - 1);

  fetch_state_e      state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic              valid_q, valid_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              stall;
  logic              timer_en;
  logic              timer_err;

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state_q <= S_ISSUE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      inst_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, capture and PC-stall decode. Flush always wins over hold.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    valid_d = 1'b0;
    cnt_d   = cnt_q;
    stall   = 1'b1;
    unique case (state_q)
      S_ISSUE: begin
        if (flush_i) begin
          stall = 1'b0;
        end else begin
          addr_d  = pc_i & ALIGN_MASK;
          req_d   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_ack_i) begin
          req_d = 1'b0;
          if (flush_i) begin
            stall   = 1'b0;
            state_d = S_ISSUE;
          end else begin
            inst_d  = mem_data_i;
            valid_d = 1'b1;
            cnt_d   = cnt_q + 32'd1;
            if (hold_i) begin
              state_d = S_HOLD;
            end else begin
              stall   = 1'b0;
              state_d = S_ISSUE;
            end
          end
        end else if (flush_i) begin
          stall   = 1'b0;
          state_d = S_DRAIN;
        end
      end
      S_HOLD: begin
        // The parked instruction stays visible until ID takes it or a
        // flush kills it; either way the bubble follows.
        valid_d = valid_q;
        if (flush_i || !hold_i) begin
          valid_d = 1'b0;
          stall   = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (flush_i) begin
          stall = 1'b0;
        end
        if (mem_ack_i) begin
          req_d   = 1'b0;
          state_d = S_ISSUE;
        end
      end
      default: begin
        state_d = S_ISSUE;
      end
    endcase
  end

  // Timer runs only while a read stays outstanding across an edge.
  always_comb begin
    timer_en = (state_q == S_WAIT || state_q == S_DRAIN) &&
               (state_d == S_WAIT || state_d == S_DRAIN);
  end

  fetch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_i   (clk_i),
    .start_i (start_i),
    .en_i    (timer_en),
    .err_o   (timer_err)
  );

  // PC is frozen whenever the controller is in reset.
  assign stall_o      = stall | ~start_i;
  assign mem_req_o    = req_q;
  assign mem_addr_o   = addr_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;
  assign fetch_cnt_o  = cnt_q;
  assign err_o        = timer_err;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed vector table, hand-written timeout and
// async-reset sequences, then randomized traffic against a flag-based model.
module tb_ifetch_ctrl;

  localparam int TIMEOUT = 16;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        start = 1'b0;
  logic [31:0] pc = '0;
  logic        flush = 1'b0;
  logic        hold = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] data = '0;
  logic        stall, req, valid, err;
  logic [31:0] addr, inst, cnt;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  ifetch_ctrl #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i        (clk),
    .start_i      (start),
    .pc_i         (pc),
    .flush_i      (flush),
    .hold_i       (hold),
    .stall_o      (stall),
    .mem_req_o    (req),
    .mem_addr_o   (addr),
    .mem_ack_i    (ack),
    .mem_data_i   (data),
    .inst_o       (inst),
    .inst_valid_o (valid),
    .fetch_cnt_o  (cnt),
    .err_o        (err),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic st, input logic [31:0] p, input logic fl,
                       input logic ho, input logic ak, input logic [31:0] d);
    @(posedge clk);
    #1;
    start = st; pc = p; flush = fl; hold = ho; ack = ak; data = d;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        st;
    logic [31:0] pc;
    logic        fl, ho, ak;
    logic [31:0] dat;
    logic        e_stall, e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_cnt;
  } vec_t;

  localparam int NV = 33;
  vec_t vt[NV];

  function automatic vec_t mk(logic st, logic [31:0] p, logic fl, logic ho, logic ak,
                              logic [31:0] d, logic es, logic er, logic [31:0] ea,
                              logic ev, logic [31:0] ei, logic [31:0] ec);
    vec_t v;
    v.st = st; v.pc = p; v.fl = fl; v.ho = ho; v.ak = ak; v.dat = d;
    v.e_stall = es; v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_inst = ei; v.e_cnt = ec;
    return v;
  endfunction

  // ---------------- reference model ----------------
  // Tracks the fetch as facts: is a read outstanding, has it been squashed,
  // is a delivered instruction parked waiting for ID.
  logic        m_req, m_sq, m_held, m_valid, m_err;
  logic [31:0] m_addr, m_inst, m_cnt;
  int          m_wc;
  logic [31:0] exp_q[$];
  logic [31:0] prev_cnt;

  task automatic model_reset();
    m_req = 0; m_sq = 0; m_held = 0; m_valid = 0; m_err = 0;
    m_addr = 0; m_inst = 0; m_cnt = 0; m_wc = 0;
    exp_q.delete();
    prev_cnt = 0;
  endtask

  function automatic logic model_stall(logic fl, logic ho, logic ak);
    if (fl) return 1'b0;
    if (m_held && !ho) return 1'b0;
    if (m_req && !m_sq && ak && !ho) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge(input logic [31:0] p, input logic fl, input logic ho,
                            input logic ak, input logic [31:0] d);
    logic still_out;
    still_out = 1'b0;
    if (m_held) begin
      if (fl || !ho) begin
        m_held  = 0;
        m_valid = 0;
      end
    end else if (m_req) begin
      m_valid = 0;
      if (ak) begin
        m_req = 0;
        if (!m_sq && !fl) begin
          m_inst  = d;
          m_valid = 1;
          m_cnt   = m_cnt + 1;
          m_held  = ho;
          exp_q.push_back(d);
        end
        m_sq = 0;
      end else begin
        still_out = 1'b1;
        if (fl) m_sq = 1;
      end
    end else begin
      m_valid = 0;
      if (!fl) begin
        m_req  = 1;
        m_addr = p & ~32'd3;
      end
    end
    if (still_out) begin
      if (m_wc < TIMEOUT - 1) m_wc++;
      if (m_wc == TIMEOUT - 1) m_err = 1;
    end else begin
      m_wc = 0;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic sb_check();
    logic [31:0] e;
    if (cnt !== prev_cnt) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("sb_inst", inst, e);
      end
      prev_cnt = cnt;
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // Directed cycle-by-cycle vectors: reset, normal fetch, hold, flush in
    // WAIT/HOLD/DRAIN/ISSUE, misaligned PC, ack while idle.
    vt[0]  = mk(0, 32'h100, 0, 0, 0, 32'h0,        1, 0, 32'h0,   0, 32'h0,        0);
    vt[1]  = mk(1, 32'h100, 0, 0, 0, 32'h0,        1, 0, 32'h0,   0, 32'h0,        0);
    vt[2]  = mk(1, 32'h100, 0, 0, 0, 32'h0,        1, 1, 32'h100, 0, 32'h0,        0);
    vt[3]  = mk(1, 32'h100, 0, 0, 1, 32'hAABB0011, 0, 1, 32'h100, 0, 32'h0,        0);
    vt[4]  = mk(1, 32'h104, 0, 0, 0, 32'h0,        1, 0, 32'h100, 1, 32'hAABB0011, 1);
    vt[5]  = mk(1, 32'h104, 0, 0, 0, 32'h0,        1, 1, 32'h104, 0, 32'hAABB0011, 1);
    vt[6]  = mk(1, 32'h104, 0, 1, 1, 32'h11111111, 1, 1, 32'h104, 0, 32'hAABB0011, 1);
    vt[7]  = mk(1, 32'h104, 0, 1, 0, 32'h0,        1, 0, 32'h104, 1, 32'h11111111, 2);
    vt[8]  = mk(1, 32'h104, 0, 1, 0, 32'h0,        1, 0, 32'h104, 1, 32'h11111111, 2);
    vt[9]  = mk(1, 32'h108, 0, 0, 0, 32'h0,        0, 0, 32'h104, 1, 32'h11111111, 2);
    vt[10] = mk(1, 32'h108, 0, 0, 0, 32'h0,        1, 0, 32'h104, 0, 32'h11111111, 2);
    vt[11] = mk(1, 32'h108, 0, 0, 0, 32'h0,        1, 1, 32'h108, 0, 32'h11111111, 2);
    vt[12] = mk(1, 32'h200, 1, 0, 0, 32'h0,        0, 1, 32'h108, 0, 32'h11111111, 2);
    vt[13] = mk(1, 32'h200, 0, 0, 0, 32'h0,        1, 1, 32'h108, 0, 32'h11111111, 2);
    vt[14] = mk(1, 32'h200, 0, 0, 0, 32'h0,        1, 1, 32'h108, 0, 32'h11111111, 2);
    vt[15] = mk(1, 32'h200, 0, 0, 1, 32'hDEADBEEF, 1, 1, 32'h108, 0, 32'h11111111, 2);
    vt[16] = mk(1, 32'h200, 0, 0, 0, 32'h0,        1, 0, 32'h108, 0, 32'h11111111, 2);
    vt[17] = mk(1, 32'h200, 0, 0, 0, 32'h0,        1, 1, 32'h200, 0, 32'h11111111, 2);
    vt[18] = mk(1, 32'h200, 0, 1, 1, 32'h22222222, 1, 1, 32'h200, 0, 32'h11111111, 2);
    vt[19] = mk(1, 32'h200, 0, 1, 0, 32'h0,        1, 0, 32'h200, 1, 32'h22222222, 3);
    vt[20] = mk(1, 32'h303, 1, 1, 0, 32'h0,        0, 0, 32'h200, 1, 32'h22222222, 3);
    vt[21] = mk(1, 32'h303, 0, 0, 0, 32'h0,        1, 0, 32'h200, 0, 32'h22222222, 3);
    vt[22] = mk(1, 32'h303, 0, 0, 0, 32'h0,        1, 1, 32'h300, 0, 32'h22222222, 3);
    vt[23] = mk(1, 32'h303, 1, 0, 1, 32'h33333333, 0, 1, 32'h300, 0, 32'h22222222, 3);
    vt[24] = mk(1, 32'h303, 0, 0, 0, 32'h0,        1, 0, 32'h300, 0, 32'h22222222, 3);
    vt[25] = mk(1, 32'h303, 1, 0, 0, 32'h0,        0, 1, 32'h300, 0, 32'h22222222, 3);
    vt[26] = mk(1, 32'h303, 1, 0, 0, 32'h0,        0, 1, 32'h300, 0, 32'h22222222, 3);
    vt[27] = mk(1, 32'h303, 0, 0, 1, 32'h44444444, 1, 1, 32'h300, 0, 32'h22222222, 3);
    vt[28] = mk(1, 32'h400, 1, 0, 0, 32'h0,        0, 0, 32'h300, 0, 32'h22222222, 3);
    vt[29] = mk(1, 32'h400, 0, 0, 0, 32'h0,        1, 0, 32'h300, 0, 32'h22222222, 3);
    vt[30] = mk(1, 32'h400, 0, 0, 1, 32'h55555555, 0, 1, 32'h400, 0, 32'h22222222, 3);
    vt[31] = mk(1, 32'h404, 0, 0, 1, 32'h66666666, 1, 0, 32'h400, 1, 32'h55555555, 4);
    vt[32] = mk(1, 32'h404, 0, 0, 0, 32'h0,        1, 1, 32'h404, 0, 32'h55555555, 4);

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].st, vt[i].pc, vt[i].fl, vt[i].ho, vt[i].ak, vt[i].dat);
      @(negedge clk);
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vt[i].e_stall));
      chk($sformatf("v%0d_req", i),   32'(req),   32'(vt[i].e_req));
      chk($sformatf("v%0d_addr", i),  addr,       vt[i].e_addr);
      chk($sformatf("v%0d_valid", i), 32'(valid), 32'(vt[i].e_valid));
      chk($sformatf("v%0d_inst", i),  inst,       vt[i].e_inst);
      chk($sformatf("v%0d_cnt", i),   cnt,        vt[i].e_cnt);
      chk($sformatf("v%0d_err", i),   32'(err),   32'd0);
    end

    // Timeout: the read for 0x404 is in its first WAIT cycle; withhold ack.
    for (int k = 1; k <= TIMEOUT + 1; k++) begin
      drive(1, 32'h404, 0, 0, 0, 32'h0);
      @(negedge clk);
      chk($sformatf("to%0d_err", k), 32'(err), (k >= TIMEOUT - 1) ? 32'd1 : 32'd0);
      chk($sformatf("to%0d_req", k), 32'(req), 32'd1);
    end
    // Late ack still delivers; error stays sticky.
    drive(1, 32'h404, 0, 0, 1, 32'h77777777);
    @(negedge clk);
    chk("late_ack_stall", 32'(stall), 32'd0);
    drive(1, 32'h500, 0, 0, 0, 32'h0);
    @(negedge clk);
    chk("late_valid", 32'(valid), 32'd1);
    chk("late_inst", inst, 32'h77777777);
    chk("late_cnt", cnt, 32'd5);
    chk("late_err", 32'(err), 32'd1);
    drive(1, 32'h500, 0, 0, 0, 32'h0);
    @(negedge clk);
    chk("rst_pre_req", 32'(req), 32'd1);
    chk("rst_pre_addr", addr, 32'h500);

    // Asynchronous reset in the middle of a WAIT cycle.
    #2 start = 1'b0;
    #1;
    chk("arst_stall", 32'(stall), 32'd1);
    chk("arst_req", 32'(req), 32'd0);
    chk("arst_addr", addr, 32'd0);
    chk("arst_inst", inst, 32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_cnt", cnt, 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_state", 32'(dbg_state), 32'd0);

    // Late ack while still in reset must be ignored.
    drive(0, 32'h600, 0, 0, 1, 32'hBAD0BAD0);
    @(negedge clk);
    chk("arst_ack_req", 32'(req), 32'd0);
    chk("arst_ack_valid", 32'(valid), 32'd0);

    // Randomized traffic against the model.
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      logic [31:0] p, d;
      logic fl, ho, ak;
      p  = $urandom;
      d  = $urandom;
      fl = ($urandom_range(0, 9) == 0);
      ho = ($urandom_range(0, 2) == 0);
      ak = ($urandom_range(0, 2) == 0);
      drive(1, p, fl, ho, ak, d);
      @(negedge clk);
      chk("r_stall", 32'(stall), 32'(model_stall(fl, ho, ak)));
      chk("r_req",   32'(req),   32'(m_req));
      chk("r_addr",  addr,       m_addr);
      chk("r_valid", 32'(valid), 32'(m_valid));
      chk("r_inst",  inst,       m_inst);
      chk("r_cnt",   cnt,        m_cnt);
      chk("r_err",   32'(err),   32'(m_err));
      sb_check();
      model_edge(p, fl, ho, ak, d);
    end
    // One more cycle so the last predicted delivery reaches the DUT outputs.
    drive(1, 32'h0, 1, 0, 0, 32'h0);
    @(negedge clk);
    sb_check();
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
